// File: rtl/hex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_pkg
//  Description : Shared 7-segment constants (active-low, bits g..a) and the
//                reader state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package hex_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h18;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      HR_SETTLING = 1'b0,
      HR_LOCKED   = 1'b1
   } hr_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational inverse of the hex-to-segment decoder. Maps an
//                active-low segment pattern to {legal, blank, value}.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
   import hex_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_legal,
   output logic       o_blank,
   output logic [3:0] o_value
);

   // Pattern lookup; anything not in the table is flagged non-legal.
   always_comb begin
      o_legal = 1'b1;
      o_blank = 1'b0;
      o_value = 4'h0;
      case (i_seg)
         SEG_0: o_value = 4'h0;
         SEG_1: o_value = 4'h1;
         SEG_2: o_value = 4'h2;
         SEG_3: o_value = 4'h3;
         SEG_4: o_value = 4'h4;
         SEG_5: o_value = 4'h5;
         SEG_6: o_value = 4'h6;
         SEG_7: o_value = 4'h7;
         SEG_8: o_value = 4'h8;
         SEG_9: o_value = 4'h9;
         SEG_A: o_value = 4'hA;
         SEG_B: o_value = 4'hB;
         SEG_C: o_value = 4'hC;
         SEG_D: o_value = 4'hD;
         SEG_E: o_value = 4'hE;
         SEG_F: o_value = 4'hF;
         SEG_BLANK: begin
            o_legal = 1'b0;
            o_blank = 1'b1;
         end
         default: o_legal = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/hex_reader.sv
`default_nettype none
// ============================================================================
//  Module      : hex_reader
//  Description : Recovers a hex digit from an active-low 7-segment bus. A
//                pattern is committed once it has been sampled unchanged for
//                STABLE_CYCLES edges; commits drive Digit/Valid/Blank/Error and
//                a one-cycle Change pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_reader
   import hex_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [6:0] HEX_IN,
   output logic [3:0] Digit,
   output logic       Valid,
   output logic       Change,
   output logic       Blank,
   output logic       Error
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] c_CNT_MAX    = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] c_CNT_COMMIT = CW'(STABLE_CYCLES - 1);

   logic [6:0]    r_sample;
   logic [CW-1:0] r_cnt;
   hr_state_t     r_state;
   hr_state_t     w_state_nxt;
   logic          w_same;
   logic          w_commit;
   logic          w_legal;
   logic          w_blank;
   logic [3:0]    w_value;

   logic [3:0]    r_digit;
   logic          r_valid;
   logic          r_change;
   logic          r_blank;
   logic          r_error;

   assign w_same = (HEX_IN == r_sample);

   seg7_decode u_decode (
      .i_seg   (HEX_IN),
      .o_legal (w_legal),
      .o_blank (w_blank),
      .o_value (w_value)
   );

   // Sample register and saturating run counter; frozen while disabled.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_sample <= SEG_BLANK;
         r_cnt    <= '0;
      end else if (Enable) begin
         r_sample <= HEX_IN;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != c_CNT_MAX)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         r_state <= HR_SETTLING;
      else
         r_state <= w_state_nxt;
   end

   // Next state and commit strobe: commit only on the SETTLING->LOCKED edge,
   // so a stable run produces exactly one commit.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      if (Enable) begin
         case (r_state)
            HR_SETTLING: begin
               if (w_same && (r_cnt == c_CNT_COMMIT)) begin
                  w_commit    = 1'b1;
                  w_state_nxt = HR_LOCKED;
               end
            end
            HR_LOCKED: begin
               if (!w_same)
                  w_state_nxt = HR_SETTLING;
            end
            default: w_state_nxt = HR_SETTLING;
         endcase
      end
   end

   // Output registers: updated only on a commit; Change is a single-cycle pulse.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_digit  <= 4'h0;
         r_valid  <= 1'b0;
         r_change <= 1'b0;
         r_blank  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_change <= 1'b0;
         if (w_commit) begin
            if (w_legal) begin
               r_digit  <= w_value;
               r_valid  <= 1'b1;
               r_blank  <= 1'b0;
               r_error  <= 1'b0;
               r_change <= (w_value != r_digit) || !r_valid;
            end else if (w_blank) begin
               r_valid <= 1'b0;
               r_blank <= 1'b1;
               r_error <= 1'b0;
            end else begin
               r_valid <= 1'b0;
               r_blank <= 1'b0;
               r_error <= 1'b1;
            end
         end
      end
   end

   assign Digit  = r_digit;
   assign Valid  = r_valid;
   assign Change = r_change;
   assign Blank  = r_blank;
   assign Error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_hex_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_reader
//  Description : Self-checking bench for hex_reader (STABLE_CYCLES = 4, plus a
//                STABLE_CYCLES = 1 instance sharing the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_reader;
   import hex_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Enable;
   logic [6:0] HEX_IN;
   logic [3:0] Digit,  Digit1;
   logic       Valid,  Valid1;
   logic       Change, Change1;
   logic       Blank,  Blank1;
   logic       Error,  Error1;

   hex_reader #(.STABLE_CYCLES(4)) u_dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .HEX_IN(HEX_IN),
      .Digit(Digit), .Valid(Valid), .Change(Change), .Blank(Blank), .Error(Error)
   );

   hex_reader #(.STABLE_CYCLES(1)) u_dut1 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .HEX_IN(HEX_IN),
      .Digit(Digit1), .Valid(Valid1), .Change(Change1), .Blank(Blank1), .Error(Error1)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [6:0] pat;
      int         cycles;
      logic [3:0] digit;
      logic       valid;
      logic       blank;
      logic       error;
      int         pulses;
   } seg_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses;
   seg_t sb[$];
   seg_t tbl_a[7];
   logic [6:0] sweep[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock edge, then settle away from the edge; counts Change pulses.
   task automatic step();
      @(posedge Clock);
      #1;
      if (Change === 1'b1) pulses++;
   endtask

   // Drive a segment, queue its expectation, then pop and compare at its end.
   task automatic run_seg(input string tag, input seg_t s);
      seg_t e;
      sb.push_back(s);
      HEX_IN = s.pat;
      Enable = 1'b1;
      pulses = 0;
      repeat (s.cycles) step();
      e = sb.pop_front();
      check({tag, " digit"},  Digit,  e.digit);
      check({tag, " valid"},  Valid,  e.valid);
      check({tag, " blank"},  Blank,  e.blank);
      check({tag, " error"},  Error,  e.error);
      check({tag, " pulses"}, pulses, e.pulses);
   endtask

   initial begin
      int total;
      tbl_a[0] = '{SEG_5,     20, 4'h5, 1'b1, 1'b0, 1'b0, 1};
      tbl_a[1] = '{SEG_9,      3, 4'h5, 1'b1, 1'b0, 1'b0, 0};
      tbl_a[2] = '{SEG_5,      6, 4'h5, 1'b1, 1'b0, 1'b0, 0};
      tbl_a[3] = '{SEG_BLANK,  6, 4'h5, 1'b0, 1'b1, 1'b0, 0};
      tbl_a[4] = '{7'h2A,      6, 4'h5, 1'b0, 1'b0, 1'b1, 0};
      tbl_a[5] = '{SEG_F,      6, 4'hF, 1'b1, 1'b0, 1'b0, 1};
      tbl_a[6] = '{SEG_B,      6, 4'hB, 1'b1, 1'b0, 1'b0, 1};
      sweep = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};

      // Reset state, then first commit of '0'.
      Reset = 1'b1; Enable = 1'b1; HEX_IN = SEG_0; pulses = 0;
      repeat (2) step();
      check("rst digit",  Digit,  0);
      check("rst valid",  Valid,  0);
      check("rst change", Change, 0);
      check("rst blank",  Blank,  0);
      check("rst error",  Error,  0);
      Reset = 1'b0;
      repeat (4) step();
      check("pre-commit valid", Valid, 0);
      step();
      check("first digit",  Digit,  0);
      check("first valid",  Valid,  1);
      check("first change", Change, 1);
      step();
      check("first change drop", Change, 0);

      // Table-driven segments up to the Enable test.
      for (int i = 0; i < 6; i++) run_seg($sformatf("tblA%0d", i), tbl_a[i]);

      // Enable low: inputs toggle, nothing may move.
      Enable = 1'b0; pulses = 0;
      for (int i = 0; i < 10; i++) begin
         HEX_IN = 7'($urandom);
         step();
      end
      check("disabled digit",  Digit,  4'hF);
      check("disabled valid",  Valid,  1);
      check("disabled pulses", pulses, 0);
      run_seg("tblA6", tbl_a[6]);

      // Run count resumes across a disabled interval.
      HEX_IN = SEG_3;
      repeat (2) step();
      Enable = 1'b0; HEX_IN = SEG_7;
      repeat (3) step();
      Enable = 1'b1; HEX_IN = SEG_3;
      repeat (2) step();
      check("resume not yet", Digit, 4'hB);
      step();
      check("resume digit",  Digit,  4'h3);
      check("resume change", Change, 1);

      // Asynchronous reset between edges with the counter at 2.
      HEX_IN = SEG_7;
      repeat (3) step();
      #3 Reset = 1'b1;
      #1;
      check("async digit",  Digit,  0);
      check("async valid",  Valid,  0);
      check("async blank",  Blank,  0);
      check("async error",  Error,  0);
      check("async digit1", Digit1, 0);
      #1 Reset = 1'b0;

      // Sweep all legal patterns; the STABLE_CYCLES=1 instance must track too.
      total = 0;
      for (int i = 0; i < 16; i++) begin
         seg_t s;
         s = '{sweep[i], 5, 4'(i), 1'b1, 1'b0, 1'b0, 1};
         run_seg($sformatf("sweep%0d", i), s);
         total += pulses;
         check($sformatf("sweep%0d digit1", i), Digit1, i);
         check($sformatf("sweep%0d valid1", i), Valid1, 1);
      end
      check("sweep total pulses", total, 16);

      // STABLE_CYCLES=1: a one-sample glitch never commits, two samples do.
      HEX_IN = SEG_2; step();
      HEX_IN = SEG_F; step();
      check("s1 glitch digit", Digit1, 4'hF);
      HEX_IN = SEG_2; step(); step();
      check("s1 commit digit", Digit1, 4'h2);

      // Held blank after reset commits on the fourth edge.
      HEX_IN = SEG_BLANK; Reset = 1'b1;
      step();
      Reset = 1'b0;
      repeat (3) step();
      check("blank pre", Blank, 0);
      step();
      check("blank post", Blank, 1);
      check("blank valid", Valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
